// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the IMEM reload controller.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE
  } state_t;

  // Default frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Byte lane that completes a little-endian 32-bit word.
  localparam logic [1:0] LANE_LAST = 2'd3;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, IMEM reload port and status flags of the loader.
// master = loader side, slave = byte source / IMEM / CPU side.
interface imem_loader_if;
  logic        rx_vld;
  logic [7:0]  rx_dat;
  logic        rx_rdy;
  logic        imem_cpu_rstn;
  logic        imem_we;
  logic [29:0] imem_waddr;
  logic [31:0] imem_wdat;
  logic        busy;
  logic        done;
  logic        err_csum;
  logic        err_len;
  logic        err_tmo;

  modport master (
    input  rx_vld, rx_dat,
    output rx_rdy, imem_cpu_rstn, imem_we, imem_waddr, imem_wdat,
    output busy, done, err_csum, err_len, err_tmo
  );

  modport slave (
    output rx_vld, rx_dat,
    input  rx_rdy, imem_cpu_rstn, imem_we, imem_waddr, imem_wdat,
    input  busy, done, err_csum, err_len, err_tmo
  );
endinterface

// File: rtl/imem_loader_wordasm.sv
// Byte-to-word assembler: collects four bytes LSB-first. word_done and word
// are combinational on the accept of the fourth byte so the top can register
// the IMEM write exactly one cycle later.
module imem_loader_wordasm
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_done,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] shreg;

  // Lane counter and shift register; cleared whenever the frame is not in DATA.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lane  <= '0;
      shreg <= '0;
    end else if (byte_vld) begin
      lane  <= lane + 2'd1;
      shreg <= {byte_dat, shreg[23:8]};
    end
  end

  assign word_done = byte_vld && (lane == LANE_LAST);
  assign word      = {byte_dat, shreg};

endmodule

// File: rtl/imem_loader.sv
// Program-reload controller: parses SYNC/LEN/DATA/CSUM frames, holds the CPU
// in reset while writing IMEM, checks length and checksum, then releases it.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned NUM_WORDS_IMEM = 8192,
  parameter int unsigned TIMEOUT_CYC    = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF
) (
  input logic           clk,
  input logic           rst,
  imem_loader_if.master bus
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS_IMEM) + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t             state;
  logic [15:0]        len;
  logic [IDX_W-1:0]   word_idx;
  logic [7:0]         sum8;
  logic [TMO_W-1:0]   tmo_cnt;

  logic               acc;
  logic               in_frame;
  logic               tmo_hit;
  logic               byte_ok;
  logic [7:0]         sum_next;
  logic [15:0]        len_full;
  logic               asm_done;
  logic [31:0]        asm_word;

  assign acc      = bus.rx_vld && bus.rx_rdy;
  assign in_frame = state inside {LEN0, LEN1, DATA, CSUM};
  // A byte landing on the timeout cycle is dropped: abort wins over accept.
  assign tmo_hit  = in_frame && (tmo_cnt == TMO_LAST);
  assign byte_ok  = acc && !tmo_hit;
  assign sum_next = sum8 + bus.rx_dat;
  assign len_full = {bus.rx_dat, len[7:0]};

  assign bus.rx_rdy = (state != DONE);
  assign bus.busy   = (state != IDLE);

  imem_loader_wordasm u_wordasm (
    .clk       (clk),
    .rst       (rst),
    .clr       (state != DATA),
    .byte_vld  (byte_ok && (state == DATA)),
    .byte_dat  (bus.rx_dat),
    .word_done (asm_done),
    .word      (asm_word)
  );

  // Frame FSM with length/checksum/timeout counters and registered IMEM port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      len               <= '0;
      word_idx          <= '0;
      sum8              <= '0;
      tmo_cnt           <= '0;
      bus.imem_cpu_rstn <= 1'b1;
      bus.imem_we       <= 1'b0;
      bus.imem_waddr    <= '0;
      bus.imem_wdat     <= '0;
      bus.done          <= 1'b0;
      bus.err_csum      <= 1'b0;
      bus.err_len       <= 1'b0;
      bus.err_tmo       <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      bus.done    <= 1'b0;

      if (in_frame && !acc) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                  tmo_cnt <= '0;

      if (tmo_hit) begin
        bus.err_tmo <= 1'b1;
        state       <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (acc && (bus.rx_dat == SYNC_BYTE)) begin
              state             <= LEN0;
              bus.imem_cpu_rstn <= 1'b0;
              bus.err_csum      <= 1'b0;
              bus.err_len       <= 1'b0;
              bus.err_tmo       <= 1'b0;
              len               <= '0;
              word_idx          <= '0;
              sum8              <= '0;
            end
          end
          LEN0: begin
            if (acc) begin
              len[7:0] <= bus.rx_dat;
              sum8     <= sum_next;
              state    <= LEN1;
            end
          end
          LEN1: begin
            if (acc) begin
              len[15:8] <= bus.rx_dat;
              sum8      <= sum_next;
              if ((len_full == '0) || (32'(len_full) > NUM_WORDS_IMEM)) begin
                bus.err_len <= 1'b1;
                state       <= IDLE;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (acc) sum8 <= sum_next;
            if (asm_done) begin
              bus.imem_we    <= 1'b1;
              bus.imem_waddr <= 30'(word_idx);
              bus.imem_wdat  <= asm_word;
              word_idx       <= word_idx + IDX_W'(1);
              if (32'(word_idx) == (32'(len) - 32'd1)) state <= CSUM;
            end
          end
          CSUM: begin
            if (acc) begin
              if (sum_next == 8'd0) begin
                state             <= DONE;
                bus.done          <= 1'b1;
                bus.imem_cpu_rstn <= 1'b1;
              end else begin
                bus.err_csum <= 1'b1;
                state        <= IDLE;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random and directed frames checked against a
// frame-level model of the expected writes and outcome.
module tb_imem_loader;

  localparam int unsigned N = 16;
  localparam int unsigned T = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_loader_if bus ();

  imem_loader #(
    .NUM_WORDS_IMEM (N),
    .TIMEOUT_CYC    (T),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] dat;
    int unsigned cyc;
  } wr_t;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int          done_cnt = 0;
  wr_t         wr_q[$];
  logic [7:0]  frame[$];
  int unsigned gap[$];
  int unsigned acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.imem_we) wr_q.push_back('{bus.imem_waddr, bus.imem_wdat, cyc});
    if (bus.done) done_cnt++;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    bus.rx_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Leaves time at the negedge following the accepting edge; acc_q holds
  // the cycle count right after that edge.
  task automatic send_byte(input logic [7:0] b, input int unsigned g);
    int unsigned w = 0;
    idle(g);
    bus.rx_vld = 1'b1;
    bus.rx_dat = b;
    while (!bus.rx_rdy && w < 8) begin
      @(negedge clk);
      w++;
    end
    if (!bus.rx_rdy) check("rx_rdy_wait", 64'(bus.rx_rdy), 64'd1);
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    bus.rx_vld = 1'b0;
  endtask

  task automatic build_frame(input int unsigned len, input int unsigned bad, input int unsigned gmax);
    logic [7:0] s;
    logic [7:0] b;
    frame.delete();
    gap.delete();
    frame.push_back(8'hA5);
    frame.push_back(len[7:0]);
    frame.push_back(len[15:8]);
    for (int unsigned i = 0; i < 4 * len; i++) begin
      b = 8'($urandom);
      frame.push_back(b);
    end
    s = 8'd0;
    for (int unsigned i = 1; i < frame.size(); i++) s = s + frame[i];
    frame.push_back(8'(8'd0 - s + 8'(bad)));
    for (int unsigned i = 0; i < frame.size(); i++) gap.push_back($urandom_range(gmax, 0));
  endtask

  task automatic build_hdr(input int unsigned len);
    frame.delete();
    gap.delete();
    frame.push_back(8'hA5);
    frame.push_back(len[7:0]);
    frame.push_back(len[15:8]);
    for (int unsigned i = 0; i < 3; i++) gap.push_back(0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_flags"},
          64'({bus.rx_rdy, bus.imem_cpu_rstn, bus.imem_we, bus.busy, bus.done,
               bus.err_csum, bus.err_len, bus.err_tmo}), 64'(8'b1100_0000));
    check({tag, "_waddr"}, 64'(bus.imem_waddr), 64'd0);
    check({tag, "_wdat"}, 64'(bus.imem_wdat), 64'd0);
  endtask

  // Sends the frame (stopping at the first byte whose gap is long enough to
  // time out) and compares the DUT against what the frame rules predict.
  task automatic run_frame(input string tag);
    int unsigned cut, got, nw, len, oc;
    logic [7:0]  s;
    logic [31:0] exp_dat;
    wr_q.delete();
    acc_q.delete();
    done_cnt = 0;
    cut = frame.size();
    for (int unsigned i = 1; i < frame.size(); i++)
      if (gap[i] >= T - 1) begin
        cut = i;
        break;
      end
    for (int unsigned i = 0; i < frame.size() && i <= cut; i++) begin
      send_byte(frame[i], gap[i]);
      if (i == 0)
        check({tag, "_sync_hold"},
              64'({bus.busy, bus.imem_cpu_rstn, bus.err_csum, bus.err_len, bus.err_tmo}),
              64'(5'b10000));
    end
    idle(4);

    // outcome: 0 done, 1 checksum error, 2 length error, 3 timeout
    got = cut;
    nw  = 0;
    s   = 8'd0;
    for (int unsigned i = 1; i < frame.size(); i++) s = s + frame[i];
    if (got < 3) begin
      oc = 3;
    end else begin
      len = {16'd0, frame[2], frame[1]};
      if (len == 0 || len > N) begin
        oc = 2;
      end else begin
        nw = (got - 3) / 4;
        if (nw > len) nw = len;
        if (got < frame.size()) oc = 3;
        else                    oc = (s == 8'd0) ? 0 : 1;
      end
    end

    check({tag, "_nwr"}, 64'(wr_q.size()), 64'(nw));
    for (int unsigned w = 0; w < nw && w < wr_q.size(); w++) begin
      exp_dat = {frame[4*w+6], frame[4*w+5], frame[4*w+4], frame[4*w+3]};
      check({tag, "_waddr"}, 64'(wr_q[w].addr), 64'(w));
      check({tag, "_wdat"}, 64'(wr_q[w].dat), 64'(exp_dat));
      check({tag, "_wcyc"}, 64'(wr_q[w].cyc), 64'(acc_q[4*w+6]));
    end
    check({tag, "_done"}, 64'(done_cnt), 64'(oc == 0 ? 1 : 0));
    check({tag, "_errs"}, 64'({bus.err_csum, bus.err_len, bus.err_tmo}),
          64'({oc == 1, oc == 2, oc == 3}));
    check({tag, "_cpu_busy"}, 64'({bus.imem_cpu_rstn, bus.busy}), 64'({oc == 0, 1'b0}));
  endtask

  initial begin
    logic [7:0] dir [8];
    dir = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEC};
    bus.rx_vld = 1'b0;
    bus.rx_dat = 8'd0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    idle(2);

    frame.delete();
    gap.delete();
    foreach (dir[i]) begin
      frame.push_back(dir[i]);
      gap.push_back(0);
    end
    run_frame("directed");
    check("dir_wdat", 64'(wr_q.size() > 0 ? wr_q[0].dat : 32'hFFFF_FFFF), 64'h13);

    repeat (6) begin
      build_frame($urandom_range(N, 1), 0, 3);
      run_frame("rand");
    end

    build_frame(3, 1, 1);
    run_frame("csum_bad");

    build_hdr(0);
    run_frame("len0");
    build_hdr(N + 1);
    run_frame("len_big");
    build_frame(2, 0, 2);
    run_frame("after_len");

    build_frame(2, 0, 1);
    gap[5]   = T + 5;
    frame[5] = 8'h3C;
    run_frame("tmo_stall");
    build_frame(3, 0, 2);
    run_frame("after_tmo");

    build_frame(1, 0, 0);
    gap[4] = T - 2;
    run_frame("gap_max_ok");
    build_frame(2, 0, 0);
    gap[8] = T - 1;
    run_frame("gap_tmo_edge");

    build_frame(N, 0, 3);
    run_frame("full");
    check("full_last_waddr", 64'(wr_q.size() > 0 ? wr_q[wr_q.size()-1].addr : 30'h3FFF_FFFF),
          64'(N - 1));

    build_frame(4, 0, 0);
    for (int unsigned i = 0; i < 9; i++) send_byte(frame[i], 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_rst");
    rst = 1'b0;
    idle(2);
    build_frame(1, 0, 2);
    run_frame("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
